// File: rtl/mem_responder.sv
// Multi-cycle memory responder shared by the fetch and data ports of proc.
// One access in flight at a time; data port wins arbitration over fetch.
module mem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_done,
  output logic        if_stall,
  input  logic        dm_rd,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic [15:0] dm_rdata,
  output logic        dm_done,
  output logic        dm_stall,
  output logic        err
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [1:0]           state;
  logic [3:0]           cnt;
  logic                 port_dm;
  logic                 op_wr;
  logic                 bad;
  logic [ADDR_BITS-1:0] idx;
  logic [15:0]          wdata_q;
  logic [15:0]          mem [DEPTH];

  logic        dm_req;
  logic        accept;
  logic        acc_bad;
  logic [15:0] acc_addr;
  logic        resp;
  logic        unused_bits;

  always_comb begin
    dm_req   = dm_rd | dm_wr;
    accept   = (state == IDLE) && (dm_req || if_req);
    acc_addr = dm_req ? dm_addr : if_addr;
    acc_bad  = acc_addr[0] | (dm_rd & dm_wr);
  end

  // Upper address bits alias onto the array by design.
  assign unused_bits = ^acc_addr[15:ADDR_BITS+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      port_dm <= 1'b0;
      op_wr   <= 1'b0;
      bad     <= 1'b0;
      idx     <= '0;
      wdata_q <= 16'h0000;
      err     <= 1'b0;
    end else begin
      if (accept && acc_bad) err <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            port_dm <= dm_req;
            op_wr   <= dm_req & dm_wr;
            bad     <= acc_bad;
            idx     <= acc_addr[ADDR_BITS:1];
            wdata_q <= dm_wdata;
            cnt     <= CNT_INIT;
            state   <= (LATENCY == 1) ? RESP : BUSY;
          end
        end
        BUSY: begin
          // Leave BUSY on the edge where the counter reaches zero.
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == RESP && op_wr && !bad) mem[idx] <= wdata_q;
  end

  always_comb begin
    resp     = (state == RESP);
    dm_done  = resp & port_dm;
    if_done  = resp & ~port_dm;
    dm_rdata = (dm_done && !op_wr && !bad) ? mem[idx] : 16'h0000;
    if_rdata = (if_done && !bad) ? mem[idx] : 16'h0000;
    if_stall = if_req & ~if_done;
    dm_stall = dm_req & ~dm_done;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: latency, arbitration, aliasing, error and reset cases.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = 16'h0;
  logic [15:0] if_rdata;
  logic        if_done, if_stall;
  logic        dm_rd = 1'b0, dm_wr = 1'b0;
  logic [15:0] dm_addr = 16'h0, dm_wdata = 16'h0;
  logic [15:0] dm_rdata;
  logic        dm_done, dm_stall, err;

  logic        l1_if_req = 1'b0;
  logic [15:0] l1_if_rdata;
  logic        l1_if_done, l1_if_stall;
  logic        l1_dm_rd = 1'b0, l1_dm_wr = 1'b0;
  logic [15:0] l1_dm_addr = 16'h0, l1_dm_wdata = 16'h0;
  logic [15:0] l1_dm_rdata;
  logic        l1_dm_done, l1_dm_stall, l1_err;

  int n_checks = 0;
  int n_errors = 0;
  logic err_at1;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_BITS(10), .LATENCY(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_done(if_done), .if_stall(if_stall),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall), .err(err)
  );

  mem_responder #(.ADDR_BITS(10), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst),
    .if_req(l1_if_req), .if_addr(16'h0000), .if_rdata(l1_if_rdata),
    .if_done(l1_if_done), .if_stall(l1_if_stall),
    .dm_rd(l1_dm_rd), .dm_wr(l1_dm_wr), .dm_addr(l1_dm_addr), .dm_wdata(l1_dm_wdata),
    .dm_rdata(l1_dm_rdata), .dm_done(l1_dm_done), .dm_stall(l1_dm_stall), .err(l1_err)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Data-port access; sample index 0 is the request cycle, done expected at index lat.
  task automatic dm_op(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [15:0] exp_rdata,
                       input int lat, input string tag);
    int done_at, stall_cnt, stray;
    done_at = -1; stall_cnt = 0; stray = 0;
    @(posedge clk); #1;
    dm_rd = rd; dm_wr = wr; dm_addr = addr; dm_wdata = wdata;
    for (int i = 0; i < 40 && done_at < 0; i++) begin
      @(negedge clk);
      if (i == 1) err_at1 = err;
      if (dm_done) begin
        done_at = i;
        check({tag, "_rdata"}, dm_rdata, exp_rdata);
      end else begin
        if (dm_stall) stall_cnt++;
        if (dm_rdata != 16'h0) stray++;
      end
    end
    dm_rd = 1'b0; dm_wr = 1'b0;
    check({tag, "_lat"}, 16'(done_at), 16'(lat));
    check({tag, "_stall"}, 16'(stall_cnt), 16'(lat));
    check({tag, "_rdata_idle"}, 16'(stray), 16'd0);
  endtask

  task automatic if_op(input logic [15:0] addr, input logic [15:0] exp_rdata,
                       input int lat, input string tag);
    int done_at, stall_cnt;
    done_at = -1; stall_cnt = 0;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = addr;
    for (int i = 0; i < 40 && done_at < 0; i++) begin
      @(negedge clk);
      if (if_done) begin
        done_at = i;
        check({tag, "_rdata"}, if_rdata, exp_rdata);
      end else if (if_stall) stall_cnt++;
    end
    if_req = 1'b0;
    check({tag, "_lat"}, 16'(done_at), 16'(lat));
    check({tag, "_stall"}, 16'(stall_cnt), 16'(lat));
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check({tag, "_done"}, {14'd0, dm_done, if_done}, 16'h0);
    check({tag, "_stall"}, {14'd0, dm_stall, if_stall}, 16'h0);
    check({tag, "_rdata"}, dm_rdata | if_rdata, 16'h0);
    check({tag, "_err"}, {15'd0, err}, 16'h0);
  endtask

  initial begin
    int dm_at, if_at, if_stall_cnt, l1_done_at;
    err_at1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_done", {14'd0, dm_done, if_done}, 16'h0);
    check("rst_stall", {14'd0, dm_stall, if_stall}, 16'h0);
    check("rst_rdata", dm_rdata | if_rdata, 16'h0);
    check("rst_err", {15'd0, err}, 16'h0);

    // 1: write then read back
    dm_op(1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 4, "t1_wr");
    dm_op(1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 4, "t1_rd");

    // 2: simultaneous fetch and data read; data first
    dm_at = -1; if_at = -1; if_stall_cnt = 0;
    @(posedge clk); #1;
    dm_rd = 1'b1; dm_addr = 16'h0010; if_req = 1'b1; if_addr = 16'h0010;
    for (int i = 0; i < 40 && if_at < 0; i++) begin
      @(negedge clk);
      if (dm_done && dm_at < 0) begin
        dm_at = i;
        check("t2_dm_rdata", dm_rdata, 16'hBEEF);
        dm_rd = 1'b0;
      end
      if (if_done) begin
        if_at = i;
        check("t2_if_rdata", if_rdata, 16'hBEEF);
      end else if (if_stall) if_stall_cnt++;
    end
    if_req = 1'b0;
    check("t2_dm_lat", 16'(dm_at), 16'd4);
    check("t2_if_lat", 16'(if_at), 16'd9);
    check("t2_if_stall", 16'(if_stall_cnt), 16'd9);

    // 3: fetch address aliases onto word 1
    dm_op(1'b0, 1'b1, 16'h0002, 16'h1234, 16'h0000, 4, "t3_wr");
    if_op(16'h0802, 16'h1234, 4, "t3_if");

    // 4: rd and wr together flags err and suppresses the write
    dm_op(1'b0, 1'b1, 16'h0020, 16'hAAAA, 16'h0000, 4, "t4_pre");
    check("t4_err_before", {15'd0, err}, 16'h0);
    dm_op(1'b1, 1'b1, 16'h0020, 16'h5555, 16'h0000, 4, "t4_bad");
    check("t4_err_next", {15'd0, err_at1}, 16'h1);
    dm_op(1'b1, 1'b0, 16'h0020, 16'h0000, 16'hAAAA, 4, "t4_rd");
    check("t4_err_sticky", {15'd0, err}, 16'h1);
    do_reset("t4_rst");

    // 5: misaligned write is flagged and dropped
    dm_op(1'b0, 1'b1, 16'h0030, 16'h7777, 16'h0000, 4, "t5_pre");
    dm_op(1'b0, 1'b1, 16'h0031, 16'h9999, 16'h0000, 4, "t5_bad");
    check("t5_err_next", {15'd0, err_at1}, 16'h1);
    dm_op(1'b1, 1'b0, 16'h0030, 16'h0000, 16'h7777, 4, "t5_rd");
    dm_op(1'b0, 1'b1, 16'h0032, 16'h4242, 16'h0000, 4, "t5_wr2");
    dm_op(1'b1, 1'b0, 16'h0032, 16'h0000, 16'h4242, 4, "t5_rd2");
    check("t5_err_sticky", {15'd0, err}, 16'h1);
    do_reset("t5_rst");

    // 6: reset two cycles into a write aborts it
    dm_op(1'b0, 1'b1, 16'h0040, 16'h1111, 16'h0000, 4, "t6_pre");
    @(posedge clk); #1;
    dm_wr = 1'b1; dm_addr = 16'h0040; dm_wdata = 16'h2222;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1; dm_wr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_out_done", {14'd0, dm_done, if_done}, 16'h0);
    check("t6_out_rdata", dm_rdata | if_rdata, 16'h0);
    dm_at = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (dm_done) dm_at++;
    end
    check("t6_no_done", 16'(dm_at), 16'd0);
    dm_op(1'b1, 1'b0, 16'h0040, 16'h0000, 16'h1111, 4, "t6_rd");

    // LATENCY=1 instance
    l1_done_at = -1;
    @(posedge clk); #1;
    l1_dm_wr = 1'b1; l1_dm_addr = 16'h0004; l1_dm_wdata = 16'hCAFE;
    for (int i = 0; i < 10 && l1_done_at < 0; i++) begin
      @(negedge clk);
      if (l1_dm_done) l1_done_at = i;
    end
    l1_dm_wr = 1'b0;
    check("l1_wr_lat", 16'(l1_done_at), 16'd1);
    l1_done_at = -1;
    @(posedge clk); #1;
    l1_dm_rd = 1'b1;
    for (int i = 0; i < 10 && l1_done_at < 0; i++) begin
      @(negedge clk);
      if (l1_dm_done) begin
        l1_done_at = i;
        check("l1_rd_rdata", l1_dm_rdata, 16'hCAFE);
      end
    end
    l1_dm_rd = 1'b0;
    check("l1_rd_lat", 16'(l1_done_at), 16'd1);
    check("l1_idle", {13'd0, l1_if_done, l1_if_stall, l1_err}, 16'h0);
    check("l1_after", {14'd0, l1_dm_stall, |l1_if_rdata}, 16'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
